case_mul_pipe_sat: RTL

CASE_MUL_PIPE_SAT -- requirements
Module: case_mul_pipe_sat

---
 rtl/case_mul_pipe_sat.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/case_mul_pipe_sat.sv
// case_mul_pipe_sat: pipelined multiply, optional round, shift, narrow with
// saturation or wrap, valid/ready handshake and a saturating overflow counter.
//
// Ports:
//   ap_clk, ap_rst_n        clock, asynchronous active-low reset
//   in_valid/in_ready       operand handshake (din0, din1)
//   out_valid/out_ready     result handshake (dout, dout_ovf)
//   ovf_clr                 synchronous clear of ovf_cnt
//   ovf_cnt                 number of delivered results that overflowed

module case_mul_pipe_sat #(
    parameter int DIN0_WIDTH = 14,
    parameter int DIN1_WIDTH = 12,
    parameter int DOUT_WIDTH = 16,
    parameter int NUM_STAGE  = 3,
    parameter int SHIFT      = 8,
    parameter int SIGNED     = 1,
    parameter int SAT        = 1,
    parameter int ROUND      = 1
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIN0_WIDTH-1:0] din0,
    input  logic [DIN1_WIDTH-1:0] din1,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DOUT_WIDTH-1:0] dout,
    output logic                  dout_ovf,
    input  logic                  ovf_clr,
    output logic [15:0]           ovf_cnt
);

    localparam int P   = DIN0_WIDTH + DIN1_WIDTH;
    localparam int DW  = DOUT_WIDTH;
    localparam int NS  = NUM_STAGE;
    localparam bit SGN = (SIGNED != 0);
    localparam bit RND = (ROUND != 0) && (SHIFT > 0);
    localparam int RSH = (SHIFT > 0) ? SHIFT - 1 : 0;

    localparam logic [P:0] RND_ADD =
        RND ? ((P+1)'(1) << RSH) : '0;

    localparam logic [DW-1:0] S_MAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0] S_MIN = {1'b1, {(DW-1){1'b0}}};
    localparam logic [DW-1:0] U_MAX = {DW{1'b1}};

    logic adv;

    logic [P-1:0] prod;
    logic [P:0]   prod_ext;
    logic [P:0]   sum;
    logic [P:0]   shf;
    logic [P:0]   hi;
    logic         res_ovf;
    logic [DW-1:0] res_dout;

    logic [NS-1:0] vld_q, vld_d;
    logic [NS-1:0] ovf_q, ovf_d;
    logic [DW-1:0] dat_q [NS];
    logic [DW-1:0] dat_d [NS];

    logic [15:0] ovf_cnt_q, ovf_cnt_d;

    // Operands are widened to the full product width first so the
    // multiply is exact for both signed and unsigned operation.
    generate
        if (SGN) begin : g_smul
            logic signed [P-1:0] a_s;
            logic signed [P-1:0] b_s;
            assign a_s  = $signed({{DIN1_WIDTH{din0[DIN0_WIDTH-1]}}, din0});
            assign b_s  = $signed({{DIN0_WIDTH{din1[DIN1_WIDTH-1]}}, din1});
            assign prod = a_s * b_s;
        end else begin : g_umul
            logic [P-1:0] a_u;
            logic [P-1:0] b_u;
            assign a_u  = {{DIN1_WIDTH{1'b0}}, din0};
            assign b_u  = {{DIN0_WIDTH{1'b0}}, din1};
            assign prod = a_u * b_u;
        end
    endgenerate

    // One guard bit above the product absorbs the rounding carry.
    always_comb begin
        prod_ext = SGN ? {prod[P-1], prod} : {1'b0, prod};
        sum      = prod_ext + RND_ADD;
        if (SGN) begin
            shf = $signed(sum) >>> SHIFT;
        end else begin
            shf = sum >> SHIFT;
        end
    end

    // Signed: value fits when every bit from DW-1 upward is a copy of
    // the sign. Unsigned: value fits when nothing is set above DW-1.
    always_comb begin
        if (SGN) begin
            hi      = $signed(shf) >>> (DW - 1);
            res_ovf = !((hi == '0) || (hi == '1));
        end else begin
            hi      = shf >> DW;
            res_ovf = (hi != '0);
        end
        res_dout = shf[DW-1:0];
        if ((SAT != 0) && res_ovf) begin
            if (SGN) begin
                res_dout = shf[P] ? S_MIN : S_MAX;
            end else begin
                res_dout = U_MAX;
            end
        end
    end

    assign out_valid = vld_q[NS-1];
    assign dout      = dat_q[NS-1];
    assign dout_ovf  = ovf_q[NS-1];

    // The whole pipe moves as one; a stalled output freezes every stage.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    always_comb begin
        vld_d = vld_q;
        ovf_d = ovf_q;
        for (int i = 0; i < NS; i++) begin
            dat_d[i] = dat_q[i];
        end
        if (adv) begin
            vld_d[0] = in_valid;
            ovf_d[0] = res_ovf;
            dat_d[0] = res_dout;
            for (int i = 1; i < NS; i++) begin
                vld_d[i] = vld_q[i-1];
                ovf_d[i] = ovf_q[i-1];
                dat_d[i] = dat_q[i-1];
            end
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            vld_q <= '0;
            ovf_q <= '0;
            for (int i = 0; i < NS; i++) begin
                dat_q[i] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            ovf_q <= ovf_d;
            for (int i = 0; i < NS; i++) begin
                dat_q[i] <= dat_d[i];
            end
        end
    end

    // Clear wins over a same-cycle increment; the count sticks at max.
    always_comb begin
        ovf_cnt_d = ovf_cnt_q;
        if (ovf_clr) begin
            ovf_cnt_d = '0;
        end else if (out_valid && out_ready && dout_ovf
                     && (ovf_cnt_q != 16'hFFFF)) begin
            ovf_cnt_d = ovf_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            ovf_cnt_q <= '0;
        end else begin
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    assign ovf_cnt = ovf_cnt_q;

endmodule
